// File: rtl/muldiv_if.sv
// muldiv_if: operand/request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      MD_func;
  logic            start;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] MD_out;
  modport master (output op1, op2, MD_func, start, flush, input busy, done, MD_out);
  modport slave  (input op1, op2, MD_func, start, flush, output busy, done, MD_out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide, 34-cycle latency.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  md
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t            state_q;
  logic [XLEN-1:0]   a_q, b_q, out_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2:0]        func_q;
  logic [CW-1:0]     cnt_q;
  logic              sa_q, sb_q, busy_q, done_q;
  logic [XLEN:0]     msum_d, trial_d, diff_d;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quo_d, rem_d, res_d;
  logic              sa_d, sb_d;
  // Multiply keeps a_q fixed and consumes b_q; divide keeps b_q fixed and consumes a_q.
  assign msum_d  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q[0] ? a_q : '0};
  assign trial_d = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign diff_d  = trial_d - {1'b0, b_q};
  assign sa_d    = a_q[XLEN-1] & (func_q[2] ? ~func_q[0] : (func_q[1] ^ func_q[0]));
  assign sb_d    = b_q[XLEN-1] & (func_q[2] ? ~func_q[0] : (func_q[1:0] == 2'd1));
  assign prod_d  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  // A zero divisor yields all-ones magnitude; forcing avoids negating it for negative dividends.
  assign quo_d   = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem_d   = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign res_d   = func_q[2] ? (func_q[1] ? rem_d : quo_d)
                 : ((func_q[1:0] == 2'd0) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN]);
`ifdef MULDIV_EARLY_OUT_EN
  logic eo_zero_d, eo_ovf_d, eo_d;
  assign eo_zero_d = md.op2 == '0;
  assign eo_ovf_d  = ~md.MD_func[0] && md.op1 == {1'b1, {(XLEN-1){1'b0}}} && md.op2 == '1;
  assign eo_d      = md.MD_func[2] & (eo_zero_d | eo_ovf_d);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      acc_q   <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (md.flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (md.start) begin
            a_q    <= md.op1;
            b_q    <= md.op2;
            func_q <= md.MD_func;
`ifdef MULDIV_EARLY_OUT_EN
            if (eo_d) begin
              state_q <= FIX;
              acc_q   <= eo_zero_d ? {md.op1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              sa_q    <= 1'b0;
              sb_q    <= 1'b0;
              b_q     <= {{(XLEN-1){1'b0}}, 1'b1};
            end else begin
              state_q <= PREP;
              busy_q  <= 1'b1;
            end
`else
            state_q <= PREP;
            busy_q  <= 1'b1;
`endif
          end
          PREP: begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= sa_d ? -a_q : a_q;
            b_q     <= sb_d ? -b_q : b_q;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
          CALC: begin
            if (func_q[2]) begin
              acc_q <= {diff_d[XLEN] ? trial_d[XLEN-1:0] : diff_d[XLEN-1:0], acc_q[XLEN-2:0], ~diff_d[XLEN]};
              a_q   <= a_q << 1;
            end else begin
              acc_q <= {msum_d, acc_q[XLEN-1:1]};
              b_q   <= b_q >> 1;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
          end
          FIX: begin
            out_q   <= res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign md.busy   = busy_q;
  assign md.done   = done_q;
  assign md.MD_out = out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, start/flush/reset behaviour.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  muldiv_if md ();
  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .md(md));
  always #5 clk = ~clk;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    @(negedge clk);
    md.op1 = a;
    md.op2 = b;
    md.MD_func = f;
    md.start = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (md.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f, input logic [31:0] exp, input int lat);
    int n;
    issue(a, b, f);
    check({tag, "_busy_T"}, {31'd0, md.busy}, {31'd0, lat > 1});
    wait_done(n);
    check({tag, "_lat"}, n, lat);
    check(tag, md.MD_out, exp);
    check({tag, "_busy_done"}, {31'd0, md.busy}, 32'd0);
  endtask
  initial begin
    int n;
    bit seen;
    logic [31:0] prev;
    md.op1 = '0;
    md.op2 = '0;
    md.MD_func = '0;
    md.start = 1'b0;
    md.flush = 1'b0;
    #12;
    check("rst_busy", {31'd0, md.busy}, 32'd0);
    check("rst_done", {31'd0, md.done}, 32'd0);
    check("rst_out", md.MD_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mul", 32'h7, 32'hFFFFFFFD, 3'd0, 32'hFFFFFFEB, 34);
    run("mulh", 32'h7, 32'hFFFFFFFD, 3'd1, 32'hFFFFFFFF, 34);
    run("mulhu", 32'h7, 32'hFFFFFFFD, 3'd3, 32'h00000006, 34);
    run("div", 32'hFFFFFFF9, 32'h2, 3'd4, 32'hFFFFFFFD, 34);
    run("rem", 32'hFFFFFFF9, 32'h2, 3'd6, 32'hFFFFFFFF, 34);
    run("divu", 32'hFFFFFFF9, 32'h2, 3'd5, 32'h7FFFFFFC, 34);
    run("div0", 32'h5, 32'h0, 3'd4, 32'hFFFFFFFF, EL);
    run("rem0", 32'h5, 32'h0, 3'd6, 32'h00000005, EL);
    run("divneg0", 32'hFFFFFFF9, 32'h0, 3'd4, 32'hFFFFFFFF, EL);
    run("divu0", 32'h12345678, 32'h0, 3'd5, 32'hFFFFFFFF, EL);
    run("divovf", 32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, EL);
    run("removf", 32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h00000000, EL);
    issue(32'h7, 32'hFFFFFFFD, 3'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    md.op1 = 32'd100;
    md.op2 = 32'd5;
    md.MD_func = 3'd4;
    md.start = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    check("ign_busy", {31'd0, md.busy}, 32'd1);
    wait_done(n);
    check("ign_lat", n, 29);
    check("ign_out", md.MD_out, 32'hFFFFFFEB);
    run("b2b", 32'd100, 32'd7, 3'd7, 32'd2, 34);
    prev = md.MD_out;
    issue(32'd3, 32'd4, 3'd0);
    repeat (10) @(posedge clk);
    #1;
    md.flush = 1'b1;
    @(posedge clk);
    #1;
    md.flush = 1'b0;
    check("flush_busy", {31'd0, md.busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (md.done === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_nodone", {31'd0, seen}, 32'd0);
    check("flush_out", md.MD_out, prev);
    issue(32'd9, 32'd9, 3'd0);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, md.busy}, 32'd0);
    check("arst_done", {31'd0, md.done}, 32'd0);
    check("arst_out", md.MD_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, 34);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
